pipe_skid_stage: RTL and testbench

//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.
//  A 2-entry skid buffer gives full throughput under back-pressure. Flush turns the stage into a bubble.

---
 rtl/pipe_skid_stage.sv | 128 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with a valid/ready handshake.
// A main register drives the outputs. A skid register absorbs the one entry that can arrive in the
// cycle downstream stalls, so the stage sustains one transfer per cycle.
// A saturating stall counter is included for performance debug.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding equals the number of entries held, so occupancy is the state itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic xfer_in;
  logic xfer_out;

  // Handshake outputs depend on registered state only.
  always_comb begin
    in_ready  = (state_q != StTwo);
    out_valid = (state_q != StEmpty);
    out_data  = main_data_q;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    occupancy = state_q;
    stall_cnt = stall_cnt_q;
    xfer_in   = in_valid & in_ready;
    xfer_out  = out_valid & out_ready;
  end

  // Next state and storage updates; flush overrides every transfer.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = StEmpty;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (xfer_in) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (xfer_in && xfer_out) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (xfer_in) begin
            // Skid entry is younger than main; it moves up when main drains.
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = StTwo;
          end else if (xfer_out) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (xfer_out) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Stall counter saturates and is deliberately left untouched by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus a random run, all checked each cycle against
// a 2-deep FIFO model (queue) with a saturating stall count.
module tb_pipe_skid_stage;

  localparam int DW   = 32;
  localparam int CW   = 8;
  localparam int NW   = 4;
  localparam int SMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CNT_W (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  item_t         mq[$];
  int            m_stall;
  logic [DW-1:0] m_last;
  int            n_cmp;
  int            n_bad;
  logic [DW-1:0] got[$];
  logic [DW-1:0] seq;
  bit            took;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int sz = mq.size();
    cmp("in_ready", 64'(in_ready), 64'(sz < 2));
    cmp("out_valid", 64'(out_valid), 64'(sz > 0));
    cmp("occupancy", 64'(occupancy), 64'(sz));
    cmp("out_ctrl", 64'(out_ctrl), (sz > 0) ? 64'(mq[0].c) : 64'(0));
    cmp("out_data", 64'(out_data), (sz > 0) ? 64'(mq[0].d) : 64'(m_last));
    cmp("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  // One clock: model consumes the inputs present at the edge, then outputs are checked.
  task automatic tick(output bit accepted);
    int sz    = mq.size();
    bit xin   = in_valid && (sz < 2);
    bit xout  = (sz > 0) && out_ready;
    item_t it;
    it.d      = in_data;
    it.c      = in_ctrl;
    accepted  = xin;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_last  = '0;
    end else begin
      if ((sz > 0) && !out_ready && (m_stall < SMAX)) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        if (xout) void'(mq.pop_front());
        if (xin) mq.push_back(it);
      end
      if (mq.size() > 0) m_last = mq[0].d;
    end
    #1;
    check_model();
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    m_stall   = 0;
    m_last    = '0;
    seq       = '0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;

    // Reset held for two cycles.
    tick(took);
    tick(took);
    cmp("rst_in_ready", 64'(in_ready), 64'd1);
    cmp("rst_out_valid", 64'(out_valid), 64'd0);
    cmp("rst_out_data", 64'(out_data), 64'd0);
    cmp("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    cmp("rst_occupancy", 64'(occupancy), 64'd0);
    cmp("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // Streaming 1..100 with no back-pressure: each item visible the cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_ctrl  = CW'(i) | CW'(1);
      cmp("stream_ready", 64'(in_ready), 64'd1);
      tick(took);
      cmp("stream_latency", 64'(out_data), 64'(i));
      cmp("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    tick(took);
    tick(took);

    // Back-pressure: A, B fill the stage, C waits upstream; drain order must be A, B, C.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    in_ctrl   = 8'h1A;
    tick(took);
    cmp("bp_occ1", 64'(occupancy), 64'd1);
    in_data = 32'hB;
    in_ctrl = 8'h1B;
    tick(took);
    cmp("bp_occ2", 64'(occupancy), 64'd2);
    cmp("bp_in_ready", 64'(in_ready), 64'd0);
    in_data = 32'hC;
    in_ctrl = 8'h1C;
    tick(took);
    tick(took);
    cmp("bp_c_held", 64'(took), 64'd0);
    cmp("bp_stall", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 8; k++) begin
      if (out_valid && out_ready) got.push_back(out_data);
      tick(took);
      if (took) in_valid = 1'b0;
    end
    cmp("bp_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      cmp("bp_order0", 64'(got[0]), 64'hA);
      cmp("bp_order1", 64'(got[1]), 64'hB);
      cmp("bp_order2", 64'(got[2]), 64'hC);
    end

    // Flush while full with an input offered in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    in_ctrl   = 8'h81;
    tick(took);
    in_data = 32'h22;
    in_ctrl = 8'h82;
    tick(took);
    cmp("fl_full", 64'(occupancy), 64'd2);
    in_data = 32'h33;
    in_ctrl = 8'h83;
    flush   = 1'b1;
    tick(took);
    flush    = 1'b0;
    in_valid = 1'b0;
    cmp("fl_occ", 64'(occupancy), 64'd0);
    cmp("fl_valid", 64'(out_valid), 64'd0);
    cmp("fl_ctrl", 64'(out_ctrl), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(took);
      cmp("fl_no_ghost", 64'(out_valid), 64'd0);
    end

    // Stall counter saturation; survives flush, cleared by reset.
    rst = 1'b1;
    tick(took);
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    in_ctrl   = 8'h5A;
    tick(took);
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick(took);
    cmp("sat_15", 64'(stall_cnt), 64'(SMAX));
    flush = 1'b1;
    tick(took);
    flush = 1'b0;
    tick(took);
    cmp("sat_after_flush", 64'(stall_cnt), 64'(SMAX));
    rst = 1'b1;
    tick(took);
    rst = 1'b0;
    cmp("sat_after_rst", 64'(stall_cnt), 64'd0);

    // Random valid/ready/flush/rst; upstream holds an offered item until it is taken.
    for (int c = 0; c < 10000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = (c % 400 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        seq      = seq + 1'b1;
        in_valid = 1'b1;
        in_data  = {seq[15:0], 16'($urandom)};
        in_ctrl  = CW'($urandom);
      end
      tick(took);
      if (took) in_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
